issue_hazard_unit: RTL and testbench

Registered hazard and forwarding controller for an N-wide in-order issue pipeline (ID -> ID_EX -> EX_MEM -> MEM_WB). It generalises the dual-lane hazard logic to LANES lanes and keeps its own shadow copies of rd, write-enable and load information for every downstream stage. New over the dual-lane logic: partial-group issue for intra-group RAW dependencies, tracked by a split-issue state machine; flush support; and youngest-writer forwarding priority. It sits beside the decode stage and drives issue masks and forwarding selects to the execute datapath.

---
 rtl/issue_hazard_unit_pkg.sv | 26 ++
 rtl/issue_hazard_unit_fwd_select.sv | 27 ++
 rtl/issue_hazard_unit.sv | 121 ++++++++++++
 tb/tb_issue_hazard_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/issue_hazard_unit_pkg.sv
// issue_hazard_unit_pkg: shared types and helpers for the issue hazard/forwarding unit.
// Register indices are stored zero-extended to REG_W_MAX bits so one shadow type
// serves every REG_W up to that width. Lane indices are carried the same way in
// fwd_sel_t, and the top keeps only the low LW bits.
package issue_hazard_unit_pkg;
  localparam int REG_W_MAX  = 16;
  localparam int LANE_W_MAX = 8;
  typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_EX_MEM = 2'd1, FWD_MEM_WB = 2'd2} fwd_stage_e;
  typedef struct packed {
    fwd_stage_e              stage;
    logic [LANE_W_MAX-1:0]   lane;
  } fwd_sel_t;
  typedef enum logic {ISSUE = 1'b0, SPLIT = 1'b1} haz_state_e;
  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] rd;
    logic [REG_W_MAX-1:0] rs1;
    logic [REG_W_MAX-1:0] rs2;
    logic                 wb;
    logic                 load;
  } shadow_entry_t;
  // Entry produces register r. Because rd != 0 is required, r == 0 never matches.
  function automatic logic writes(shadow_entry_t e, logic [REG_W_MAX-1:0] r);
    return e.valid && e.wb && e.rd != '0 && e.rd == r;
  endfunction
endpackage

// File: rtl/issue_hazard_unit_fwd_select.sv
// fwd_select: youngest-writer forwarding picker for one source operand.
// Ports: rs (operand register), ex_mem/mem_wb (shadow stages), sel ({stage, lane}).
// EX_MEM beats MEM_WB. Within a stage the highest lane wins, because later loop
// iterations overwrite earlier ones.
module fwd_select
  import issue_hazard_unit_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [REG_W_MAX-1:0] rs,
  input  shadow_entry_t        ex_mem [LANES],
  input  shadow_entry_t        mem_wb [LANES],
  output fwd_sel_t             sel
);
  logic unused_fields;
  always_comb begin
    sel = '{stage: FWD_NONE, lane: '0};
    unused_fields = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (writes(mem_wb[i], rs)) sel = '{stage: FWD_MEM_WB, lane: LANE_W_MAX'(i)};
      unused_fields = unused_fields ^ (^{ex_mem[i].rs1, ex_mem[i].rs2, ex_mem[i].load,
                                         mem_wb[i].rs1, mem_wb[i].rs2, mem_wb[i].load});
    end
    for (int i = 0; i < LANES; i++)
      if (writes(ex_mem[i], rs)) sel = '{stage: FWD_EX_MEM, lane: LANE_W_MAX'(i)};
  end
endmodule

// File: rtl/issue_hazard_unit.sv
// issue_hazard_unit: N-wide in-order issue hazard and forwarding controller.
// Inputs: clk, rst_n (async active-low), id_valid/id_rs1/id_rs2/id_rd/id_wb/id_load
//   (the decode group; lane 0 is oldest), flush.
// Outputs: issue_mask, id_advance, stall, fwd_a/fwd_b (per ID_EX lane {stage, lane}).
// Optional: with ISSUE_HAZ_STATS_EN defined, the saturating counters stall_cnt
//   and split_cnt are added.
// All outputs are forced to 0 while rst_n is low, even when the ID inputs are live.
module issue_hazard_unit
  import issue_hazard_unit_pkg::*;
#(
  parameter int LANES = 2,
  parameter int REG_W = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [LANES-1:0]                     id_valid,
  input  logic [LANES*REG_W-1:0]               id_rs1,
  input  logic [LANES*REG_W-1:0]               id_rs2,
  input  logic [LANES*REG_W-1:0]               id_rd,
  input  logic [LANES-1:0]                     id_wb,
  input  logic [LANES-1:0]                     id_load,
  input  logic                                 flush,
  output logic [LANES-1:0]                     issue_mask,
  output logic                                 id_advance,
  output logic [LANES*(2+(LANES>1?$clog2(LANES):1))-1:0] fwd_a,
  output logic [LANES*(2+(LANES>1?$clog2(LANES):1))-1:0] fwd_b,
  output logic                                 stall
`ifdef ISSUE_HAZ_STATS_EN
  ,
  output logic [31:0]                          stall_cnt,
  output logic [31:0]                          split_cnt
`endif
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int FW = 2 + LW;
  haz_state_e state, state_n;
  logic [LANES-1:0] done_mask, done_n, pend, iss, blk;
  shadow_entry_t cur [LANES];
  shadow_entry_t id_ex [LANES];
  shadow_entry_t ex_mem [LANES];
  shadow_entry_t mem_wb [LANES];
  always_comb
    for (int i = 0; i < LANES; i++)
      cur[i] = '{valid: id_valid[i],
                 rd:    REG_W_MAX'(id_rd[i*REG_W +: REG_W]),
                 rs1:   REG_W_MAX'(id_rs1[i*REG_W +: REG_W]),
                 rs2:   REG_W_MAX'(id_rs2[i*REG_W +: REG_W]),
                 wb:    id_wb[i],
                 load:  id_load[i]};
  // Hazard detection and in-order issue selection. Lanes already done, and
  // invalid lanes, are outside pend. They neither block nor issue.
  always_comb begin
    logic stop;
    pend = id_valid & ~done_mask;
    blk  = '0;
    iss  = '0;
    stop = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < LANES; k++)
        if (id_ex[k].valid && id_ex[k].load && id_ex[k].rd != '0 &&
            (id_ex[k].rd == cur[i].rs1 || id_ex[k].rd == cur[i].rs2)) blk[i] = 1'b1;
      for (int j = 0; j < LANES; j++)
        if (j < i && pend[j] && (writes(cur[j], cur[i].rs1) || writes(cur[j], cur[i].rs2)))
          blk[i] = 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      iss[i] = pend[i] && !stop && !blk[i];
      stop   = stop || (pend[i] && blk[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ISSUE;
      done_mask <= '0;
    end else begin
      state     <= state_n;
      done_mask <= done_n;
    end
  always_comb begin
    state_n = id_advance ? ISSUE :
              (state == ISSUE && issue_mask != '0 && issue_mask != pend) ? SPLIT : state;
    done_n  = id_advance ? '0 : done_mask | issue_mask;
  end
  always_comb begin
    issue_mask = (rst_n && !flush) ? iss : '0;
    id_advance = rst_n && (flush || (pend != '0 && iss == pend));
    stall      = rst_n && !flush && pend != '0 && iss == '0;
  end
  // Unissued lanes enter ID_EX as all-zero bubbles, so their rs fields never forward.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < LANES; i++) begin
        id_ex[i]  <= '0;
        ex_mem[i] <= '0;
        mem_wb[i] <= '0;
      end
    else begin
      for (int i = 0; i < LANES; i++) id_ex[i] <= issue_mask[i] ? cur[i] : '0;
      ex_mem <= id_ex;
      mem_wb <= ex_mem;
    end
  for (genvar g = 0; g < LANES; g++) begin : g_fwd
    fwd_sel_t sa, sb;
    logic unused_lane;
    fwd_select #(.LANES(LANES)) u_a (.rs(id_ex[g].rs1), .ex_mem(ex_mem), .mem_wb(mem_wb), .sel(sa));
    fwd_select #(.LANES(LANES)) u_b (.rs(id_ex[g].rs2), .ex_mem(ex_mem), .mem_wb(mem_wb), .sel(sb));
    assign fwd_a[g*FW +: FW] = {sa.stage, sa.lane[LW-1:0]};
    assign fwd_b[g*FW +: FW] = {sb.stage, sb.lane[LW-1:0]};
    assign unused_lane = ^{sa.lane, sb.lane};
  end
`ifdef ISSUE_HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      split_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (state == ISSUE && state_n == SPLIT && split_cnt != '1) split_cnt <= split_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_issue_hazard_unit.sv
// tb_issue_hazard_unit: scoreboard bench with an instruction-level pipeline model.
module tb_issue_hazard_unit;
  localparam int L = 2, RW = 5, LW = 1, FW = 2 + LW;
  logic clk = 0, rst_n = 0, flush = 0;
  logic [L-1:0] id_valid = 0, id_wb = 0, id_load = 0, issue_mask;
  logic [L*RW-1:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic id_advance, stall;
  logic [L*FW-1:0] fwd_a, fwd_b;
`ifdef ISSUE_HAZ_STATS_EN
  logic [31:0] stall_cnt, split_cnt;
`endif
  always #5 clk = ~clk;
  issue_hazard_unit #(.LANES(L), .REG_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_wb(id_wb), .id_load(id_load), .flush(flush),
    .issue_mask(issue_mask), .id_advance(id_advance), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
`ifdef ISSUE_HAZ_STATS_EN
    , .stall_cnt(stall_cnt), .split_cnt(split_cnt)
`endif
  );
  typedef struct packed {logic v; logic [RW-1:0] rd, rs1, rs2; logic wb, ld;} ins_t;
  typedef struct packed {logic [L-1:0] im; logic adv, st; logic [L*FW-1:0] fa, fb;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, m_stall = 0, m_split = 0;
  ins_t grp[L], idex[L], exm[L], mwb[L];
  logic [L-1:0] done;
  bit last_adv;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, got, want, $time);
    end
  endtask

  function automatic ins_t mk(bit v, int rd, int rs1, int rs2, bit wb, bit ld);
    return '{v: v, rd: RW'(rd), rs1: RW'(rs1), rs2: RW'(rs2), wb: wb, ld: ld};
  endfunction

  function automatic ins_t rnd();
    return mk($urandom % 4 != 0, $urandom % 8, $urandom % 8, $urandom % 8,
              $urandom % 4 != 0, $urandom % 3 == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin idex[i] = '0; exm[i] = '0; mwb[i] = '0; end
    done = '0; m_stall = 0; m_split = 0; last_adv = 1;
  endtask

  // Youngest producer of rs: search EX_MEM from the highest lane down, then MEM_WB.
  function automatic logic [FW-1:0] fsel(logic [RW-1:0] rs);
    if (rs == 0) return '0;
    for (int k = L - 1; k >= 0; k--) if (exm[k].v && exm[k].wb && exm[k].rd == rs) return {2'd1, LW'(k)};
    for (int k = L - 1; k >= 0; k--) if (mwb[k].v && mwb[k].wb && mwb[k].rd == rs) return {2'd2, LW'(k)};
    return '0;
  endfunction

  function automatic bit blocked(int i, logic [L-1:0] pend);
    for (int k = 0; k < L; k++)
      if (idex[k].v && idex[k].ld && idex[k].rd != 0 &&
          (idex[k].rd == grp[i].rs1 || idex[k].rd == grp[i].rs2)) return 1;
    for (int j = 0; j < i; j++)
      if (pend[j] && grp[j].wb && grp[j].rd != 0 &&
          (grp[j].rd == grp[i].rs1 || grp[j].rd == grp[i].rs2)) return 1;
    return 0;
  endfunction

  // One clock: drive the group, predict and queue the outputs, advance the model.
  // The task is entered and left 1 time unit after a rising edge.
  task automatic cycle(input ins_t g0, input ins_t g1, input bit fl);
    logic [L-1:0] pend, iss;
    exp_t e;
    grp[0] = g0; grp[1] = g1;
    id_valid = {g1.v, g0.v}; id_rd = {g1.rd, g0.rd}; id_rs1 = {g1.rs1, g0.rs1};
    id_rs2 = {g1.rs2, g0.rs2}; id_wb = {g1.wb, g0.wb}; id_load = {g1.ld, g0.ld}; flush = fl;
    pend = id_valid & ~done;
    iss = '0;
    for (int i = 0; i < L; i++) begin
      if (!pend[i]) continue;
      if (blocked(i, pend)) break;
      iss[i] = 1;
    end
    if (fl) iss = '0;
    e.im = iss;
    e.adv = fl || (pend != 0 && iss == pend);
    e.st = !fl && pend != 0 && iss == 0;
    for (int i = 0; i < L; i++) begin
      e.fa[i*FW +: FW] = idex[i].v ? fsel(idex[i].rs1) : '0;
      e.fb[i*FW +: FW] = idex[i].v ? fsel(idex[i].rs2) : '0;
    end
    q.push_back(e);
    if (e.st) m_stall++;
    if (!fl && done == 0 && iss != 0 && iss != pend) m_split++;
    mwb = exm; exm = idex;
    for (int i = 0; i < L; i++) idex[i] = iss[i] ? grp[i] : '0;
    done = e.adv ? '0 : done | iss;
    last_adv = e.adv;
    @(posedge clk); #1;
  endtask

  task automatic send(input ins_t g0, input ins_t g1);
    int n = 0;
    do begin cycle(g0, g1, 0); n++; end while (!last_adv && n < 8);
    if (!last_adv) chk("send_bound", 0, 1);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_issue_mask"}, issue_mask, 0);
    chk({n, "_id_advance"}, id_advance, 0);
    chk({n, "_stall"}, stall, 0);
    chk({n, "_fwd_a"}, fwd_a, 0);
    chk({n, "_fwd_b"}, fwd_b, 0);
`ifdef ISSUE_HAZ_STATS_EN
    chk({n, "_stall_cnt"}, stall_cnt, 0);
    chk({n, "_split_cnt"}, split_cnt, 0);
`endif
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("issue_mask", issue_mask, e.im);
        chk("id_advance", id_advance, e.adv);
        chk("stall", stall, e.st);
        chk("fwd_a", fwd_a, e.fa);
        chk("fwd_b", fwd_b, e.fb);
      end
    end
  end

  initial begin
    ins_t nop, r0, r1;
    bit fresh;
    nop = '0;
    model_reset();
    id_valid = 2'b11; id_rs1 = '1; id_rs2 = '1;
    #12 chk_zero("reset");
    @(posedge clk); #1 rst_n = 1;
    // Load-use: the load sits in ID_EX lane 0 while the consumer waits in ID.
    send(mk(1, 5, 0, 0, 1, 1), nop);
    send(mk(1, 1, 5, 0, 1, 0), mk(1, 2, 2, 0, 1, 0));
    // Intra-group RAW: the group splits into two single-lane issues.
    send(mk(1, 3, 0, 0, 1, 0), mk(1, 4, 0, 3, 1, 0));
    // Two EX_MEM writers of r7: the younger lane 1 must be selected.
    send(mk(1, 7, 0, 0, 1, 0), mk(1, 7, 1, 1, 1, 0));
    send(mk(1, 8, 7, 0, 1, 0), nop);
    cycle(nop, nop, 0);
    // MEM_WB-only match on r9 for ID_EX lane 1 rs2.
    send(mk(1, 9, 0, 0, 1, 0), nop);
    cycle(nop, nop, 0);
    send(mk(1, 10, 1, 1, 1, 0), mk(1, 11, 2, 9, 1, 0));
    cycle(nop, nop, 0);
    // Writers of r0 never forward.
    send(mk(1, 0, 0, 0, 1, 0), mk(1, 0, 0, 0, 1, 0));
    send(mk(1, 12, 0, 0, 1, 0), nop);
    cycle(nop, nop, 0);
    // Flush during SPLIT, then re-present: the group must split again from scratch.
    cycle(mk(1, 6, 1, 1, 1, 0), mk(1, 13, 6, 2, 1, 0), 0);
    cycle(mk(1, 6, 1, 1, 1, 0), mk(1, 13, 6, 2, 1, 0), 1);
    send(mk(1, 6, 1, 1, 1, 0), mk(1, 13, 6, 2, 1, 0));
    // Asynchronous reset between edges while in SPLIT.
    cycle(mk(1, 4, 1, 1, 1, 0), mk(1, 5, 4, 4, 1, 0), 0);
    #2 rst_n = 0;
    #1 chk_zero("mid_split_reset");
    @(posedge clk); #1 rst_n = 1;
    model_reset();
    send(mk(1, 4, 1, 1, 1, 0), mk(1, 5, 4, 4, 1, 0));
    // Random groups; the group is held until the model reports id_advance.
    fresh = 1;
    r0 = nop; r1 = nop;
    repeat (500) begin
      if (fresh || last_adv) begin r0 = rnd(); r1 = rnd(); end
      fresh = 0;
      cycle(r0, r1, $urandom % 16 == 0);
    end
    flush = 0; id_valid = '0;
    @(negedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
`ifdef ISSUE_HAZ_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("split_cnt", split_cnt, m_split);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
